de1_sw_debounce: RTL and testbench
==================================

// Module: de1_sw_debounce
// PURPOSE
//  Board-level conditioner for the DE1 slide switches, ahead of the SoC GPIO input.
//  - Synchronises raw SW pads into the wb_clk domain and debounces each bit independently.
//  - Drives clean levels onto the SoC gpio0_i bus.
//  - Emits one-cycle rise/fall pulses per bit.
//  - Holds a sticky change flag with a clear handshake, for polling or interrupt use.
// PARAMETERS
//  WIDTH         8        number of switch bits
//  TICK_DIV      24000    wb_clk cycles per debounce tick (1 ms at 24 MHz); must be >= 2
//  STABLE_TICKS  10       consecutive ticks a new level must persist before it is accepted; must be >= 1
//  RESET_VALUE   8'h00    value of the sync stages and sw_o at reset
// PORTS
//  clock      in   1      wb_clk domain clock
//  reset_n    in   1      asynchronous, active-low reset
//  sw_i       in   WIDTH  raw switch pads, asynchronous
//  sw_o       out  WIDTH  debounced level (feeds gpio0_i)
//  rise_o     out  WIDTH  1-cycle pulse: bit of sw_o went 0->1
//  fall_o     out  WIDTH  1-cycle pulse: bit of sw_o went 1->0
//  evt_o      out  1      sticky: some bit of sw_o changed since the last clear
//  evt_clr_i  in   1      synchronous clear of evt_o
// BEHAVIOUR
//  Reset (reset_n low, async assert):
//   - sync0/sync1 = RESET_VALUE; sw_o = RESET_VALUE.
//   - All counters = 0; rise_o = fall_o = 0; evt_o = 0.
//   - Deassertion is assumed synchronised upstream by the clkgen.
//  Synchroniser:
//   - 2-FF chain sw_i -> sync0 -> sync1. Only sync1 is used downstream.
//  Tick generator (shared):
//   - tcnt counts 0..TICK_DIV-1 and wraps.
//   - tick = (tcnt == TICK_DIV-1), asserted for one cycle.
//  Per bit i:
//   - If sync1[i] == sw_o[i]: cnt[i] <= 0 every cycle. A glitch therefore restarts the window.
//   - Otherwise, on tick: if cnt[i] == STABLE_TICKS-1, then sw_o[i] <= sync1[i] and cnt[i] <= 0;
//     else cnt[i] <= cnt[i] + 1.
//   - cnt width = $clog2(STABLE_TICKS+1). The counter never exceeds STABLE_TICKS-1 and never wraps.
//   - rise_o[i] / fall_o[i] are registered: high exactly in the cycle after sw_o[i] updates.
//  Latency:
//   - From the first sync1 mismatch to the sw_o update is between (STABLE_TICKS-1)*TICK_DIV+1
//     and STABLE_TICKS*TICK_DIV cycles.
//   - Add 2 cycles from the pad to sync1.
//  Sticky event:
//   - Set when any rise_o or fall_o bit is high.
//   - evt_clr_i clears it on the next edge.
//   - Set and clear in the same cycle: set wins, so no event is lost.
//  Multiple bits:
//   - Bits may update in the same tick; their pulses coincide.
//  Reset mid-window:
//   - Pending counts are discarded and no pulse is emitted.
//   - After release, a pad differing from RESET_VALUE needs a full window before it reaches sw_o.
// STRUCTURE
//  - de1_board_defs.vh (shared `defines): DE1_WB_CLK_HZ, DE1_DEBOUNCE_MS.
//    The top level computes TICK_DIV = DE1_WB_CLK_HZ/1000 and STABLE_TICKS = DE1_DEBOUNCE_MS.
//  - Sub-module de1_debounce_bit: one bit's counter, level register and edge pulses.
//    Inputs: clock, reset_n, tick, level_i. It is instantiated WIDTH times in a generate loop.
//  - Parent holds the synchroniser, tick generator and sticky event register.
// TESTING  (TICK_DIV=4, STABLE_TICKS=3, RESET_VALUE=0, WIDTH=8)
//  1. Reset, then sw_i=8'h01 held.
//     -> sw_o stays 0 for at least 9 cycles after sync.
//     -> sw_o becomes 8'h01 within 12+2 cycles; rise_o=8'h01 for exactly 1 cycle; evt_o=1.
//  2. sw_i[0] drops to 0 for 5 cycles, then returns to 1.
//     -> sw_o stays 8'h01; no fall_o pulse; evt_o unchanged.
//  3. sw_i 8'h01->8'hF0 in one cycle.
//     -> In the same cycle: fall_o=8'h01 and rise_o=8'hF0; sw_o=8'hF0 afterwards.
//  4. Pulse evt_clr_i in the same cycle as a rise_o pulse.
//     -> evt_o stays 1.
//     -> A later lone evt_clr_i clears evt_o to 0.
//  5. Assert reset_n low mid-window (2 ticks into a change).
//     -> Outputs return to reset values asynchronously with no pulses.
//     -> After release, the full window is required again.
//  6. Toggle sw_i[3] every 4 cycles for 200 cycles.
//     -> sw_o[3] never changes; cnt[3] never exceeds 2.

Source files
------------

// File: rtl/de1_sw_debounce_pkg.sv
// Shared board constants and helpers for the DE1 slide-switch conditioner.
// Board-level clock/debounce defaults live here so every importer sees the same values.
`ifndef DE1_WB_CLK_HZ
`define DE1_WB_CLK_HZ 24000000
`endif
`ifndef DE1_DEBOUNCE_MS
`define DE1_DEBOUNCE_MS 10
`endif

package de1_sw_debounce_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_TICK_DIV     = `DE1_WB_CLK_HZ / 1000;
    localparam int DEF_STABLE_TICKS = `DE1_DEBOUNCE_MS;

    // Per-bit edge pulses, kept together so the bit cell exports one bundle.
    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    // Counter only has to hold 0..stable-1; the +1 keeps stable==1 at one bit.
    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

    function automatic int tick_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/de1_debounce_bit.sv
// One switch bit: tick-counted stability window, accepted level register, edge pulses.
// Latency: (STABLE_TICKS-1)*TICK_DIV+1 .. STABLE_TICKS*TICK_DIV cycles; pulses one cycle after level_o; no backpressure.
// Backpressure: none, pulses are fire-and-forget.
module de1_debounce_bit
    import de1_sw_debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  tick,
    input  logic  level_i,
    output logic  level_o,
    output edge_t edge_o
);

    localparam int             CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_d;
    edge_t         edge_q;
    logic          mismatch;
    logic          accept;

    assign mismatch = (level_i != level_q);
    assign accept   = mismatch && tick && (cnt_q == CNT_LAST);

    // Any cycle where the input agrees with the accepted level restarts the window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!mismatch) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= accept ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= RESET_LEVEL;
        end else if (accept) begin
            level_q <= level_i;
        end
    end

    // level_d trails level_q by a cycle, so the pulse lands the cycle after the update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_d     <= RESET_LEVEL;
            edge_q.rise <= 1'b0;
            edge_q.fall <= 1'b0;
        end else begin
            level_d     <= level_q;
            edge_q.rise <= level_q & ~level_d;
            edge_q.fall <= ~level_q & level_d;
        end
    end

    assign level_o = level_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/de1_sw_debounce.sv
// DE1 slide-switch conditioner: 2-FF sync, shared tick, per-bit debounce, sticky change flag.
// Latency: 2 sync cycles plus the debounce window; pulses one cycle after sw_o; evt_o one cycle after a pulse.
// Backpressure: none; evt_o holds until evt_clr_i, with a new event winning over a same-cycle clear.
module de1_sw_debounce
    import de1_sw_debounce_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               TICK_DIV     = DEF_TICK_DIV,
    parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             evt_o,
    input  logic             evt_clr_i
);

    localparam int            TW        = tick_width(TICK_DIV);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [TW-1:0]    tcnt;
    logic             tick;
    logic             evt_q;
    logic             evt_set;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= RESET_VALUE;
            sync1 <= RESET_VALUE;
        end else begin
            sync0 <= sw_i;
            sync1 <= sync0;
        end
    end

    assign tick = (tcnt == TCNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            edge_t bit_edge;

            de1_debounce_bit #(
                .STABLE_TICKS (STABLE_TICKS),
                .RESET_LEVEL  (RESET_VALUE[gi])
            ) u_bit (
                .clock   (clock),
                .reset_n (reset_n),
                .tick    (tick),
                .level_i (sync1[gi]),
                .level_o (sw_o[gi]),
                .edge_o  (bit_edge)
            );

            assign rise_o[gi] = bit_edge.rise;
            assign fall_o[gi] = bit_edge.fall;
        end
    endgenerate

    assign evt_set = (|rise_o) | (|fall_o);

    // Set has priority so an event arriving with a clear is never dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            evt_q <= 1'b0;
        end else if (evt_set) begin
            evt_q <= 1'b1;
        end else if (evt_clr_i) begin
            evt_q <= 1'b0;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: tb/tb_de1_sw_debounce.sv
// Bench for de1_sw_debounce with TICK_DIV=4, STABLE_TICKS=3: directed steps plus random pad traffic,
// every cycle compared against a time-window reference model.
module tb_de1_sw_debounce;

    localparam int W      = 8;
    localparam int DIV    = 4;
    localparam int STABLE = 3;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] sw_i;
    logic [W-1:0] sw_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         evt_o;
    logic         evt_clr_i;

    int checks = 0;
    int errors = 0;

    de1_sw_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (DIV),
        .STABLE_TICKS (STABLE),
        .RESET_VALUE  (8'h00)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sw_i      (sw_i),
        .sw_o      (sw_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .evt_o     (evt_o),
        .evt_clr_i (evt_clr_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: pad seen two edges late; a bit flips once STABLE tick edges
    // (edge index k with k%DIV == DIV-1) have elapsed since its mismatch began.
    logic [W-1:0] m_s0, m_s1, m_out, m_prev, m_rise, m_fall;
    logic         m_evt;
    int           n_edge;
    int           pend [W];

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_out = '0; m_prev = '0;
        m_rise = '0; m_fall = '0; m_evt = 1'b0; n_edge = 0;
        for (int i = 0; i < W; i++) pend[i] = -1;
    endtask

    task automatic model_edge();
        logic [W-1:0] nout;
        logic         nevt;
        int           ticks;
        nout = m_out;
        for (int i = 0; i < W; i++) begin
            if (m_s1[i] == m_out[i]) begin
                pend[i] = -1;
            end else begin
                if (pend[i] < 0) pend[i] = n_edge;
                ticks = (n_edge + 1) / DIV - pend[i] / DIV;
                if (ticks >= STABLE) begin
                    nout[i] = m_s1[i];
                    pend[i] = -1;
                end
            end
        end
        nevt   = ((m_rise != 0) || (m_fall != 0)) ? 1'b1 : (evt_clr_i ? 1'b0 : m_evt);
        m_rise = m_out & ~m_prev;
        m_fall = ~m_out & m_prev;
        m_prev = m_out;
        m_out  = nout;
        m_s1   = m_s0;
        m_s0   = sw_i;
        m_evt  = nevt;
        n_edge++;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h at edge %0d", tag, got, exp, n_edge);
        end
    endtask

    task automatic check_all();
        chk("sw_o", sw_o, m_out);
        chk("rise_o", rise_o, m_rise);
        chk("fall_o", fall_o, m_fall);
        chk("evt_o", {7'b0, evt_o}, {7'b0, m_evt});
    endtask

    // One clock: model steps on the active edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clock);
        if (!reset_n) model_reset();
        else          model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) cyc();
    endtask

    initial begin
        logic [W-1:0] hold_val;
        logic         found;
        logic         sw3_ref;

        reset_n   = 1'b0;
        sw_i      = '0;
        evt_clr_i = 1'b0;
        model_reset();
        run(3);
        chk("reset_sw_o", sw_o, 8'h00);
        chk("reset_pulses", rise_o | fall_o, 8'h00);
        chk("reset_evt", {7'b0, evt_o}, 8'h00);

        // 1: single bit rises after a full window
        reset_n = 1'b1;
        sw_i    = 8'h01;
        run(11);
        chk("t1_still_low", sw_o, 8'h00);
        run(1);
        chk("t1_level", sw_o, 8'h01);
        run(1);
        chk("t1_rise", rise_o, 8'h01);
        run(1);
        chk("t1_rise_gone", rise_o, 8'h00);
        chk("t1_evt", {7'b0, evt_o}, 8'h01);
        run(4);

        // 2: short glitch must not get through
        sw_i = 8'h00;
        run(5);
        sw_i = 8'h01;
        run(20);
        chk("t2_level", sw_o, 8'h01);

        // 3: simultaneous fall and rise
        sw_i = 8'hF0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            cyc();
            if (fall_o != 0) begin
                found = 1'b1;
                chk("t3_fall", fall_o, 8'h01);
                chk("t3_rise", rise_o, 8'hF0);
            end
        end
        chk("t3_pulse_seen", {7'b0, found}, 8'h01);
        run(3);
        chk("t3_level", sw_o, 8'hF0);

        // 4: clear coinciding with a pulse loses to the event, a lone clear works
        sw_i = 8'hF1;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            cyc();
            if (m_rise != 0) found = 1'b1;
        end
        chk("t4_pulse_seen", {7'b0, found}, 8'h01);
        evt_clr_i = 1'b1;
        cyc();
        evt_clr_i = 1'b0;
        chk("t4_set_wins", {7'b0, evt_o}, 8'h01);
        run(3);
        evt_clr_i = 1'b1;
        cyc();
        evt_clr_i = 1'b0;
        chk("t4_cleared", {7'b0, evt_o}, 8'h00);
        run(2);

        // 5: async reset two ticks into a change
        sw_i = 8'hF3;
        run(10);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("t5_async_level", sw_o, 8'h00);
        run(2);
        reset_n = 1'b1;
        run(11);
        chk("t5_full_window", sw_o, 8'h00);
        run(3);
        chk("t5_after_window", sw_o, 8'hF3);
        run(3);

        // 6: sw_i[3] chatters faster than any window
        sw3_ref  = m_out[3];
        hold_val = sw_i;
        for (int c = 0; c < 200; c++) begin
            if (c % 4 == 0) hold_val[3] = ~hold_val[3];
            sw_i = hold_val;
            cyc();
            checks++;
            assert (dut.g_bit[3].u_bit.cnt_q <= 2) else begin
                errors++;
                $error("FAIL t6_cnt got=%0d expected<=2", dut.g_bit[3].u_bit.cnt_q);
            end
        end
        chk("t6_sw3_stuck", {7'b0, sw_o[3]}, {7'b0, sw3_ref});

        // Random pad traffic with glitches and random clears
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 3) == 0) sw_i = sw_i ^ (8'h01 << $urandom_range(0, 7));
            else                           sw_i = W'($urandom);
            for (int c = 0; c < int'($urandom_range(1, 20)); c++) begin
                evt_clr_i = ($urandom_range(0, 7) == 0);
                cyc();
            end
            evt_clr_i = 1'b0;
        end
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
